// File: rtl/gshare_predictor_pkg.sv
// Shared declarations for the gshare predictor: history sizing, the tracking-slot
// record and the 2-bit saturating counter helpers.
package common;

    localparam logic [6:0] B_TYPE      = 7'b1100011;
    localparam int         GHR_BITS    = 8;
    localparam int         PHT_ENTRIES = 2 ** GHR_BITS;

    typedef struct packed {
        logic                valid;
        logic [GHR_BITS-1:0] idx;
        logic                pred;
    } pred_slot_t;

    function automatic logic [1:0] sat2_inc(input logic [1:0] cnt);
        return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    endfunction

    function automatic logic [1:0] sat2_dec(input logic [1:0] cnt);
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// Pattern history table: one 2-bit saturating counter per history index, with a
// combinational read port and a single training port.
module gshare_pht
    import common::*;
#(
    parameter logic [1:0] COUNTER_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [GHR_BITS-1:0] rd_idx,
    output logic [1:0]          rd_cnt,
    input  logic                upd_en,
    input  logic [GHR_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    logic [1:0] cnt_reg [PHT_ENTRIES];

    // Asynchronous reset of every counter keeps this in registers rather than RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                cnt_reg[i] <= COUNTER_INIT;
            end
        end else if (upd_en) begin
            cnt_reg[upd_idx] <= upd_taken ? sat2_inc(cnt_reg[upd_idx])
                                          : sat2_dec(cnt_reg[upd_idx]);
        end
    end

    // Read sees the pre-update value; a same-cycle write shows up next cycle.
    assign rd_cnt = cnt_reg[rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor top: history register, two-stage prediction tracking and
// misprediction statistics around the shared pattern history table.
module gshare_predictor
    import common::*;
#(
    parameter logic [1:0] COUNTER_INIT = 2'b01,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             prediction,
    input  logic             advance,
    input  logic             flush,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] predict_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [GHR_BITS-1:0] ghr_reg;
    logic [GHR_BITS-1:0] lookup_idx;
    logic [1:0]          rd_cnt;
    logic                upd;
    pred_slot_t          slot1_reg;
    pred_slot_t          slot2_reg;
    logic [CNT_W-1:0]    predict_cnt_reg;
    logic [CNT_W-1:0]    mispredict_cnt_reg;
    logic                unused_pc;

    assign unused_pc  = ^{lookup_pc[31:GHR_BITS+2], lookup_pc[1:0]};
    assign lookup_idx = lookup_pc[GHR_BITS+1:2] ^ ghr_reg;
    assign prediction = lookup_valid & rd_cnt[1];

    // A resolve only counts when slot 2 holds a live branch and it leaves EX this cycle.
    assign upd        = resolve_valid & slot2_reg.valid & (advance | flush);
    assign mispredict = upd & (resolve_taken != slot2_reg.pred);

    gshare_pht #(
        .COUNTER_INIT(COUNTER_INIT)
    ) u_pht (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (lookup_idx),
        .rd_cnt   (rd_cnt),
        .upd_en   (upd),
        .upd_idx  (slot2_reg.idx),
        .upd_taken(resolve_taken)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_reg            <= '0;
            slot1_reg          <= '0;
            slot2_reg          <= '0;
            predict_cnt_reg    <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            if (flush) begin
                slot1_reg.valid <= 1'b0;
                slot2_reg.valid <= 1'b0;
            end else if (advance) begin
                slot1_reg <= '{valid: lookup_valid, idx: lookup_idx, pred: prediction};
                slot2_reg <= slot1_reg;
            end

            // History is architectural: shifted only by resolved outcomes.
            if (upd) begin
                ghr_reg <= {ghr_reg[GHR_BITS-2:0], resolve_taken};
                if (predict_cnt_reg != {CNT_W{1'b1}}) begin
                    predict_cnt_reg <= predict_cnt_reg + CNT_W'(1);
                end
                if (mispredict && (mispredict_cnt_reg != {CNT_W{1'b1}})) begin
                    mispredict_cnt_reg <= mispredict_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign predict_cnt    = predict_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule
